// File: rtl/clock_stop_ctrl.sv
// Clock-stop/restart controller: handshakes a gated domain into quiescence,
// drains, drops the clock-gate enable, and restarts it with a settle period.
module clock_stop_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int WAKE_CYCLES  = 2,
  parameter int IDLE_TIMEOUT = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stop_req,
  input  logic             wake_evt,
  input  logic             core_idle,
  output logic             halt_req,
  output logic             clk_en,
  output logic             stopped,
  output logic             stop_abort,
  output logic [CNT_W-1:0] off_count
);

  typedef enum logic [2:0] {RUN, REQ, DRAIN, OFF, WAKE} state_t;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
  localparam logic [WW-1:0] WAKE_LOAD  = WW'(WAKE_CYCLES - 1);
  localparam logic [7:0]    TO_LAST    = 8'(IDLE_TIMEOUT - 1);
  localparam logic          TO_EN      = (IDLE_TIMEOUT != 0);

  state_t           state_reg, state_next;
  logic             armed_reg, armed_next;
  logic [7:0]       to_cnt_reg, to_cnt_next;
  logic [DW-1:0]    drain_cnt_reg, drain_cnt_next;
  logic [WW-1:0]    wake_cnt_reg, wake_cnt_next;
  logic [CNT_W-1:0] off_count_reg, off_count_next;
  logic             abort_reg, abort_next;
  logic             halt_reg, clk_en_reg, stopped_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RUN;
      armed_reg     <= 1'b1;
      to_cnt_reg    <= '0;
      drain_cnt_reg <= '0;
      wake_cnt_reg  <= '0;
      off_count_reg <= '0;
      abort_reg     <= 1'b0;
      halt_reg      <= 1'b0;
      clk_en_reg    <= 1'b1;
      stopped_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      armed_reg     <= armed_next;
      to_cnt_reg    <= to_cnt_next;
      drain_cnt_reg <= drain_cnt_next;
      wake_cnt_reg  <= wake_cnt_next;
      off_count_reg <= off_count_next;
      abort_reg     <= abort_next;
      halt_reg      <= (state_next != RUN);
      clk_en_reg    <= (state_next != OFF);
      stopped_reg   <= (state_next == OFF);
    end
  end

  always_comb begin
    state_next     = state_reg;
    to_cnt_next    = to_cnt_reg;
    drain_cnt_next = drain_cnt_reg;
    wake_cnt_next  = wake_cnt_reg;
    off_count_next = off_count_reg;
    abort_next     = 1'b0;
    // Re-arming needs stop_req seen low; a wake or abort disarms and wins.
    armed_next     = armed_reg | ~stop_req;

    case (state_reg)
      RUN: begin
        if (stop_req && armed_reg && !wake_evt) begin
          state_next  = REQ;
          to_cnt_next = '0;
        end
      end
      REQ: begin
        if (wake_evt || !stop_req) begin
          state_next = RUN;
        end else if (core_idle) begin
          state_next     = DRAIN;
          drain_cnt_next = DRAIN_LOAD;
        end else if (TO_EN && (to_cnt_reg == TO_LAST)) begin
          state_next = RUN;
          abort_next = 1'b1;
          armed_next = 1'b0;
        end else begin
          to_cnt_next = to_cnt_reg + 8'd1;
        end
      end
      DRAIN: begin
        if (wake_evt || !stop_req || !core_idle) begin
          state_next = RUN;
        end else if (drain_cnt_reg == '0) begin
          state_next     = OFF;
          off_count_next = '0;
        end else begin
          drain_cnt_next = drain_cnt_reg - DW'(1);
        end
      end
      OFF: begin
        if (off_count_reg != '1) off_count_next = off_count_reg + CNT_W'(1);
        if (wake_evt || !stop_req) begin
          state_next    = WAKE;
          wake_cnt_next = WAKE_LOAD;
          armed_next    = 1'b0;
        end
      end
      WAKE: begin
        if (wake_cnt_reg == '0) state_next = RUN;
        else wake_cnt_next = wake_cnt_reg - WW'(1);
      end
      default: state_next = RUN;
    endcase
  end

  assign halt_req   = halt_reg;
  assign clk_en     = clk_en_reg;
  assign stopped    = stopped_reg;
  assign stop_abort = abort_reg;
  assign off_count  = off_count_reg;

endmodule
